// File: rtl/mem_arb_pkg.sv
// mem_arbiter shared types and default sizing.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN.
package mem_arb_pkg;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_WIDTH      = 16;
  localparam int DEF_TIMEOUT    = 15;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory bundle for mem_arbiter.
// master drives commands and responses; slave is the arbiter.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int WIDTH      = DEF_WIDTH
);

  logic                  r0_valid;
  logic                  r0_wr_rd;
  logic [ADDR_WIDTH-1:0] r0_addr;
  logic [WIDTH-1:0]      r0_wdata;
  logic                  r0_ready;
  logic [WIDTH-1:0]      r0_rdata;
  logic                  r0_err;

  logic                  r1_valid;
  logic                  r1_wr_rd;
  logic [ADDR_WIDTH-1:0] r1_addr;
  logic [WIDTH-1:0]      r1_wdata;
  logic                  r1_ready;
  logic [WIDTH-1:0]      r1_rdata;
  logic                  r1_err;

  logic                  mem_valid;
  logic                  mem_wr_rd;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0]      mem_wdata;
  logic                  mem_ready;
  logic [WIDTH-1:0]      mem_rdata;

  modport master (
    output r0_valid, r0_wr_rd,
    output r0_addr, r0_wdata,
    input  r0_ready, r0_rdata, r0_err,
    output r1_valid, r1_wr_rd,
    output r1_addr, r1_wdata,
    input  r1_ready, r1_rdata, r1_err,
    input  mem_valid, mem_wr_rd,
    input  mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );

  modport slave (
    input  r0_valid, r0_wr_rd,
    input  r0_addr, r0_wdata,
    output r0_ready, r0_rdata, r0_err,
    input  r1_valid, r1_wr_rd,
    input  r1_addr, r1_wdata,
    output r1_ready, r1_rdata, r1_err,
    output mem_valid, mem_wr_rd,
    output mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

endinterface

// File: rtl/mem_arb_grant.sv
// Two-way grant select: contention goes to the
// requester that was not granted last.
module mem_arb_grant (
  input  logic v0,
  input  logic v1,
  input  logic last,
  output logic gnt
);

  assign gnt = (v0 && v1) ? ~last : v1;

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester single-port memory arbiter with timeout.
// MEM_ARB_ROUND_ROBIN_EN enables round-robin contention.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int WIDTH      = DEF_WIDTH,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  r0_valid,
  input  logic                  r0_wr_rd,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [WIDTH-1:0]      r0_wdata,
  output logic                  r0_ready,
  output logic [WIDTH-1:0]      r0_rdata,
  output logic                  r0_err,
  input  logic                  r1_valid,
  input  logic                  r1_wr_rd,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [WIDTH-1:0]      r1_wdata,
  output logic                  r1_ready,
  output logic [WIDTH-1:0]      r1_rdata,
  output logic                  r1_err,
  output logic                  mem_valid,
  output logic                  mem_wr_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  input  logic                  mem_ready,
  input  logic [WIDTH-1:0]      mem_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

  state_t        state;
  logic          gnt;
  logic          gsel;
  logic          last;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic          fin;
  logic [WIDTH-1:0] fin_data;

  assign cnt_nx = cnt + CW'(1);
  assign fin    = mem_ready || (cnt_nx == TMO);

  always_comb begin
    fin_data = '0;
    if (mem_ready)
      fin_data = mem_rdata;
  end

  mem_arb_grant u_grant (
    .v0   (r0_valid),
    .v1   (r1_valid),
    .last (last),
    .gnt  (gsel)
  );

`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (rst)
      last <= 1'b1;
    else if (state == IDLE &&
             (r0_valid || r1_valid))
      last <= gsel;
  end
`else
  // Constant pointer makes requester 0 win.
  assign last = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= 1'b0;
      cnt       <= '0;
      mem_valid <= 1'b0;
      mem_wr_rd <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      r0_ready  <= 1'b0;
      r0_rdata  <= '0;
      r0_err    <= 1'b0;
      r1_ready  <= 1'b0;
      r1_rdata  <= '0;
      r1_err    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (r0_valid || r1_valid) begin
            gnt       <= gsel;
            cnt       <= '0;
            mem_valid <= 1'b1;
            mem_wr_rd <= gsel ? r1_wr_rd
                              : r0_wr_rd;
            mem_addr  <= gsel ? r1_addr
                              : r0_addr;
            mem_wdata <= gsel ? r1_wdata
                              : r0_wdata;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (!mem_ready && cnt != TMO)
            cnt <= cnt_nx;
          if (fin) begin
            mem_valid <= 1'b0;
            state     <= DONE;
            // Writes leave rdata untouched.
            if (gnt) begin
              r1_ready <= 1'b1;
              r1_err   <= ~mem_ready;
              if (!mem_wr_rd || !mem_ready)
                r1_rdata <= fin_data;
            end else begin
              r0_ready <= 1'b1;
              r0_err   <= ~mem_ready;
              if (!mem_wr_rd || !mem_ready)
                r0_rdata <= fin_data;
            end
          end
        end
        DONE: begin
          r0_ready <= 1'b0;
          r0_err   <= 1'b0;
          r1_ready <= 1'b0;
          r1_err   <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, memory address width.
REQ-002 SHALL have parameter WIDTH, default 16, data width.
REQ-003 SHALL have parameter TIMEOUT, default 15, maximum cycles to wait for mem_ready before aborting.
REQ-004 SHALL have port clk, input, 1, single clock; all logic on the rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have ports rN_valid (input, 1), rN_wr_rd (input, 1, 1=write), rN_addr (input, ADDR_WIDTH) and rN_wdata (input, WIDTH) for N=0,1, the requester commands.
REQ-007 SHALL have ports rN_ready (output, 1), rN_rdata (output, WIDTH) and rN_err (output, 1) for N=0,1, the per-requester completion signals.
REQ-008 SHALL have ports mem_valid, mem_wr_rd (output, 1), mem_addr (output, ADDR_WIDTH) and mem_wdata (output, WIDTH), the memory command.
REQ-009 SHALL have ports mem_ready (input, 1) and mem_rdata (input, WIDTH), the memory response; mem_rdata is valid in the mem_ready cycle.

Function
REQ-010 SHALL implement FSM states IDLE, ISSUE and DONE.
REQ-011 IDLE: if any rN_valid=1, register the winner's wr_rd/addr/wdata and grant id, clear the timeout counter, and go to ISSUE next cycle.
REQ-012 ISSUE: mem_valid=1 with registered fields held stable; on mem_ready=1, capture mem_rdata when the command is a read and go to DONE.
REQ-013 ISSUE: if the wait counter reaches TIMEOUT with mem_ready=0, drop mem_valid, set the granted rN_err and go to DONE.
REQ-014 DONE: pulse the granted rN_ready for exactly one cycle, with rN_rdata valid on reads, then return to IDLE.
REQ-015 Minimum latency SHALL be rN_valid sampled at cycle T, mem_valid at T+1, and rN_ready at T+2 if mem_ready=1 at T+1.
REQ-016 Requesters SHALL hold rN_valid and fields until rN_ready; rN_valid dropped mid-transaction is ignored until DONE.
REQ-017 Both valid in IDLE: the winner is chosen per REQ-024/REQ-025; the loser waits with rN_ready=0.
REQ-018 rN_err SHALL be a one-cycle pulse coincident with rN_ready; on timeout, rN_rdata is 0.
REQ-019 rN_rdata of the non-granted requester SHALL hold its previous value.
REQ-020 A mem_ready=1 outside ISSUE SHALL be ignored.
REQ-021 The wait counter SHALL be $clog2(TIMEOUT+1) bits wide and saturate at TIMEOUT.

Reset
REQ-022 While rst=1: state=IDLE, every output=0 (mem_valid, mem_wr_rd, mem_addr, mem_wdata, rN_ready, rN_rdata, rN_err), counter=0, and last-grant pointer=1 so requester 0 wins first.
REQ-023 Reset asserted in ISSUE or DONE SHALL abort the transaction with no rN_ready pulse; outputs are 0 on the cycle after rst is sampled.

Configuration
REQ-024 With MEM_ARB_ROUND_ROBIN_EN defined, contention SHALL grant the requester not granted last, and the pointer updates at each grant.
REQ-025 Without MEM_ARB_ROUND_ROBIN_EN, requester 0 SHALL always win contention and no pointer register exists.

Structure
REQ-026 Package mem_arb_pkg SHALL hold the FSM state enum, the default widths and the default TIMEOUT.
REQ-027 Grant selection SHALL be a sub-module mem_arb_grant (inputs: two valids, last pointer; output: grant id); the remaining logic stays in mem_arbiter.

Verification
REQ-028 Single write: r0 write addr=0x10 wdata=0xABCD, mem_ready at first ISSUE cycle -> mem_valid=1 for 1 cycle with addr 0x10 and data 0xABCD, r0_ready at T+2.
REQ-029 Read: r1 read addr=0x05, mem_ready after 3 wait cycles with mem_rdata=0x1234 -> r1_rdata=0x1234, r1_ready at T+5, r1_err=0.
REQ-030 Contention with round-robin enabled: r0 and r1 valid continuously for 4 transactions -> grants r0,r1,r0,r1; with the macro undefined -> r0 wins every contended cycle.
REQ-031 Timeout: r0 read, mem_ready held 0 -> mem_valid high TIMEOUT cycles, then r0_ready=1 and r0_err=1 on the same cycle, r0_rdata=0.
REQ-032 Reset mid-ISSUE: assert rst during the 2nd wait cycle -> all outputs 0 the next cycle, no r0_ready, and the first post-reset grant goes to r0.
REQ-033 Stray mem_ready=1 in IDLE -> no rN_ready or state change.
